// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor, D = A - B - Bin (mod 2^N).
// A single full-subtractor slice is reused for N clocks, processing the LSB first.
// The borrow out of the last slice becomes Bout.
//
// Handshake: a request is taken on a rising edge where start=1 and the FSM is
// in IDLE. That edge samples A, B and Bin; the inputs are free to change after it.
// busy is high for the N SHIFT cycles. done is a one-cycle Moore pulse in the
// cycle after the last SHIFT cycle. D and Bout change only on the edge that
// enters DONE, and they hold until the next completion. start is not queued, and
// it has no effect while busy or done is high.
module serial_subtractor #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] D,
   output logic         Bout,
   output logic [1:0]   state_o
);

   // Counter wide enough to count 0..N-1. It has at least 1 bit, so N=1 still works.
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  a_sh_q, a_sh_d;
   logic [N-1:0]  b_sh_q, b_sh_d;
   logic [N-1:0]  r_sh_q, r_sh_d;
   logic          brw_q, brw_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  d_q, d_d;
   logic          bout_q, bout_d;

   // One full-subtractor slice and the result shift value it produces.
   logic          x_bit, y_bit, diff_bit, brw_next;
   logic [N-1:0]  r_shifted;

   // Full-subtractor slice: it acts on the current LSBs of the operand shifters.
   always_comb begin
      x_bit     = a_sh_q[0];
      y_bit     = b_sh_q[0];
      diff_bit  = x_bit ^ y_bit ^ brw_q;
      brw_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
      // The new difference bit enters at the MSB. After N shifts, the first bit
      // computed has reached bit 0. Using a shift here keeps N=1 well formed.
      r_shifted = N'({diff_bit, r_sh_q} >> 1);
   end

   // Next-state logic and datapath updates. Defaults hold every register.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = A;
               b_sh_d  = B;
               brw_d   = Bin;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            r_sh_d = r_shifted;
            brw_d  = brw_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // Last slice: publish the full result together with the final borrow.
               d_d     = r_shifted;
               bout_d  = brw_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any operation in flight and clears the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         r_sh_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         r_sh_q  <= r_sh_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
      end
   end

   // Moore outputs. They are decoded only from the state register.
   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign D       = d_q;
   assign Bout    = bout_q;
   assign state_o = state_q;

   // Protocol invariants: busy and done are exclusive, and done lasts exactly one cycle.
   a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
   a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor. It drives instances with N=3, N=1 and N=8 from one clock.
// It checks results against plain-integer arithmetic and checks the busy/done timing.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;

   // Clock generation
   always #5 clk = ~clk;

   // N=3 instance
   logic       st3, bin3, busy3, done3, bout3;
   logic [2:0] a3, b3, d3;
   logic [1:0] dbg3;
   // N=1 instance
   logic       st1, bin1, busy1, done1, bout1;
   logic [0:0] a1, b1, d1;
   logic [1:0] dbg1;
   // N=8 instance
   logic       st8, bin8, busy8, done8, bout8;
   logic [7:0] a8, b8, d8;
   logic [1:0] dbg8;

   serial_subtractor #(.N(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(st3), .A(a3), .B(b3), .Bin(bin3),
      .busy(busy3), .done(done3), .D(d3), .Bout(bout3), .state_o(dbg3));
   serial_subtractor #(.N(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .Bin(bin1),
      .busy(busy1), .done(done1), .D(d1), .Bout(bout1), .state_o(dbg1));
   serial_subtractor #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .Bin(bin8),
      .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .state_o(dbg8));

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int a;
      int b;
      int bin;
      int d;
      int bo;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the subtraction done on integers, with the borrow taken from the sign.
   function automatic void model(input int n, input int a, input int b, input int bin,
                                 output int d, output int bo);
      int r;
      r  = a - b - bin;
      bo = (r < 0) ? 1 : 0;
      d  = (r + (1 << n)) % (1 << n);
   endfunction

   function automatic int width_of(input int inst);
      return (inst == 0) ? 3 : (inst == 1) ? 1 : 8;
   endfunction

   task automatic set_in(input int inst, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic bin);
      case (inst)
         0: begin st3 = s; a3 = a[2:0]; b3 = b[2:0]; bin3 = bin; end
         1: begin st1 = s; a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; end
         default: begin st8 = s; a8 = a; b8 = b; bin8 = bin; end
      endcase
   endtask

   // Output bundle: {busy, done, bout, d zero-extended to 8 bits}
   function automatic logic [10:0] get_out(input int inst);
      case (inst)
         0: return {busy3, done3, bout3, 5'd0, d3};
         1: return {busy1, done1, bout1, 7'd0, d1};
         default: return {busy8, done8, bout8, d8};
      endcase
   endfunction

   // Driver task. It starts one operation from IDLE and checks the busy/done timing
   // cycle by cycle. It checks the result on the done cycle and returns in IDLE.
   task automatic run_op(input int inst, input int a, input int b, input int bin,
                         input int exp_d, input int exp_bo);
      int          n;
      logic [10:0] o;
      bit          hs_ok;
      n     = width_of(inst);
      hs_ok = 1'b1;
      set_in(inst, 1'b1, 8'(a), 8'(b), 1'(bin));
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         o = get_out(inst);
         if (o[10] !== (c <= n) || o[9] !== (c == n + 1)) hs_ok = 1'b0;
         if (c == n + 1) begin
            check($sformatf("D n=%0d a=%0d b=%0d bin=%0d", n, a, b, bin), {24'd0, o[7:0]}, exp_d);
            check($sformatf("Bout n=%0d a=%0d b=%0d bin=%0d", n, a, b, bin), {31'd0, o[8]}, exp_bo);
         end
         // Operands scrambled after acceptance must not leak into the result.
         if (c == 1) set_in(inst, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      check($sformatf("handshake n=%0d a=%0d b=%0d", n, a, b), {31'd0, hs_ok}, 1);
      @(negedge clk);
      o = get_out(inst);
      check($sformatf("idle after done n=%0d", n), {30'd0, o[10:9]}, 0);
   endtask

   task automatic run_model_op(input int inst, input int a, input int b, input int bin);
      int ed, eb;
      model(width_of(inst), a, b, bin, ed, eb);
      run_op(inst, a, b, bin, ed, eb);
   endtask

   // Scoreboard monitor. busy and done must never be high together on any instance.
   // The N=3 result must hold between done pulses.
   logic [3:0] held;
   bit         held_v = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         compared++;
         if ((busy3 && done3) || (busy1 && done1) || (busy8 && done8)) begin
            mismatched++;
            $display("FAIL busy_done_overlap: got busy3/done3=%b%b busy1/done1=%b%b busy8/done8=%b%b expected no overlap",
                     busy3, done3, busy1, done1, busy8, done8);
         end
         if (done3) begin
            held   = {bout3, d3};
            held_v = 1'b1;
         end else if (held_v) begin
            compared++;
            if ({bout3, d3} !== held) begin
               mismatched++;
               $display("FAIL result_hold: got %0d expected %0d", {bout3, d3}, held);
            end
         end
      end
   end

   // Watchdog. Every wait in the bench is bounded, so this is only a last resort.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Main test sequence
   initial begin
      int  ed, eb;
      bit  ok;

      tbl[0] = '{a: 5, b: 3, bin: 0, d: 2, bo: 0};
      tbl[1] = '{a: 3, b: 5, bin: 0, d: 6, bo: 1};
      tbl[2] = '{a: 0, b: 0, bin: 1, d: 7, bo: 1};
      tbl[3] = '{a: 7, b: 7, bin: 0, d: 0, bo: 0};
      tbl[4] = '{a: 6, b: 1, bin: 1, d: 4, bo: 0};
      tbl[5] = '{a: 0, b: 7, bin: 1, d: 0, bo: 1};
      tbl[6] = '{a: 7, b: 0, bin: 1, d: 6, bo: 0};
      tbl[7] = '{a: 4, b: 4, bin: 1, d: 7, bo: 1};

      // Reset block
      rst_n = 1'b0;
      set_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
      set_in(1, 1'b0, 8'd0, 8'd0, 1'b0);
      set_in(2, 1'b0, 8'd0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("reset outputs inst=%0d", i), {21'd0, get_out(i)}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table for N=3
      for (int i = 0; i < 8; i++) run_op(0, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo);

      // Boundary vectors for N=1 and N=8
      run_op(1, 0, 1, 1, 0, 1);
      run_op(1, 1, 0, 0, 1, 0);
      run_op(1, 1, 1, 1, 1, 1);
      run_op(2, 0, 255, 1, 0, 1);
      run_op(2, 255, 0, 0, 255, 0);
      run_op(2, 128, 128, 1, 255, 1);

      // start held high: one result every N+2 cycles. Operand changes during SHIFT have no effect.
      @(negedge clk);
      st3 = 1'b1; a3 = 3'd6; b3 = 3'd1; bin3 = 1'b0;
      bin3 = 1'b1;
      ok = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done3 !== (c % 5 == 4)) ok = 1'b0;
         if (done3) begin
            check($sformatf("hold-start D c=%0d", c), {29'd0, d3}, 4);
            check($sformatf("hold-start Bout c=%0d", c), {31'd0, bout3}, 0);
         end
         if (c % 5 == 1) begin a3 = 3'd0; b3 = 3'd7; bin3 = 1'b0; end
         if (c % 5 == 4) begin a3 = 3'd6; b3 = 3'd1; bin3 = 1'b1; end
      end
      check("hold-start done period", {31'd0, ok}, 1);
      st3 = 1'b0;
      @(negedge clk);

      // Reset in the middle of SHIFT
      run_op(0, 5, 3, 0, 2, 0);
      set_in(0, 1'b1, 8'd7, 8'd1, 1'b0);
      @(negedge clk);
      st3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async reset busy", {31'd0, busy3}, 0);
      check("async reset D", {29'd0, d3}, 0);
      check("async reset Bout", {31'd0, bout3}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done3 !== 1'b0 || busy3 !== 1'b0) ok = 1'b0;
      end
      check("no done after reset abort", {31'd0, ok}, 1);
      run_op(0, 6, 2, 1, 3, 0);

      // Exhaustive N=3 against the model
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++) run_model_op(0, a, b, c);

      // Randomised runs for N=1 and N=8
      for (int i = 0; i < 32; i++)
         run_model_op(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      for (int i = 0; i < 96; i++)
         run_model_op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      model(8, 17, 200, 1, ed, eb);
      run_op(2, 17, 200, 1, ed, eb);

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
